// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream packet arbiter.
// Merges NUM_PORTS slave streams into one master stream feeding a shared FIFO.
// A port keeps the output for a whole packet. Data passes straight through
// with no register stage. One IDLE cycle always separates two packets.
module axis_rr_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                            s_axis_clk,
   input  logic                            s_axis_reset,
   input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]            s_axis_tlast,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
   output logic [NUM_PORTS-1:0]            s_axis_tready,
   output logic                            m_axis_tvalid,
   output logic                            m_axis_tlast,
   output logic [DATA_WIDTH-1:0]           m_axis_tdata,
   input  logic                            m_axis_tready,
   output logic [NUM_PORTS-1:0]            grant_o,
   output logic                            busy_o,
   output logic [15:0]                     pkt_count_o
);

   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      PASS = 1'b1
   } state_t;

   state_t                 state_q;
   logic [NUM_PORTS-1:0]   grant_q;
   logic [IDX_W-1:0]       owner_q;
   logic [IDX_W-1:0]       last_grant_q;
   logic [15:0]            pkt_count_q;

   logic [IDX_W:0]         rr_sel;
   logic                   own_valid;
   logic                   own_last;
   logic [DATA_WIDTH-1:0]  own_data;
   logic                   pass_active;
   logic                   beat_xfer;
   logic                   pkt_done;

   // Round-robin search: first requester strictly after 'last', wrapping.
   // Returns {found, index}.
   function automatic logic [IDX_W:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                              input logic [IDX_W-1:0]     last);
      logic [IDX_W:0]   res;
      logic [IDX_W-1:0] idx;
      int               cand;
      res = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         cand = (int'(last) + k) % NUM_PORTS;
         idx  = IDX_W'(cand);
         if (!res[IDX_W] && req[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   assign pass_active = (state_q == PASS);
   assign rr_sel      = rr_pick(s_axis_tvalid, last_grant_q);

   // Select the locked owner's stream with constant-index slices
   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (owner_q == IDX_W'(i)) begin
            own_valid = s_axis_tvalid[i];
            own_last  = s_axis_tlast[i];
            own_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Pass-through toward the FIFO; data forced to zero when not valid
   always_comb begin
      m_axis_tvalid = pass_active & own_valid;
      m_axis_tlast  = pass_active & own_last;
      m_axis_tdata  = m_axis_tvalid ? own_data : '0;
      s_axis_tready = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (pass_active && (owner_q == IDX_W'(i))) begin
            s_axis_tready[i] = m_axis_tready;
         end
      end
   end

   assign beat_xfer = m_axis_tvalid & m_axis_tready;
   assign pkt_done  = beat_xfer & m_axis_tlast;

   // Arbitration FSM: grant in IDLE, hold the lock in PASS until tlast transfers
   always_ff @(posedge s_axis_clk) begin
      if (s_axis_reset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         owner_q      <= '0;
         last_grant_q <= IDX_W'(NUM_PORTS - 1);
         pkt_count_q  <= '0;
      end else begin
         pkt_count_q <= pkt_count_q + 16'(pkt_done);
         case (state_q)
            IDLE: begin
               if (rr_sel[IDX_W]) begin
                  state_q <= PASS;
                  owner_q <= rr_sel[IDX_W-1:0];
                  grant_q <= NUM_PORTS'(1) << rr_sel[IDX_W-1:0];
               end
            end
            PASS: begin
               if (pkt_done) begin
                  state_q      <= IDLE;
                  grant_q      <= '0;
                  last_grant_q <= owner_q;
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

   assign grant_o     = grant_q;
   assign busy_o      = pass_active;
   assign pkt_count_o = pkt_count_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed testbench for axis_rr_arbiter (4 ports, 32-bit data).
// Inputs change on the falling edge. Outputs are sampled 1 ns later.
module tb_axis_rr_arbiter;

   localparam int NP = 4;
   localparam int DW = 32;

   logic              s_axis_clk;
   logic              s_axis_reset;
   logic [NP-1:0]     s_axis_tvalid;
   logic [NP-1:0]     s_axis_tlast;
   logic [NP*DW-1:0]  s_axis_tdata;
   logic [NP-1:0]     s_axis_tready;
   logic              m_axis_tvalid;
   logic              m_axis_tlast;
   logic [DW-1:0]     m_axis_tdata;
   logic              m_axis_tready;
   logic [NP-1:0]     grant_o;
   logic              busy_o;
   logic [15:0]       pkt_count_o;

   logic [DW-1:0]     pdata [NP];

   int n_checks;
   int n_errors;

   assign s_axis_tdata = {pdata[3], pdata[2], pdata[1], pdata[0]};

   axis_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
      .s_axis_clk    (s_axis_clk),
      .s_axis_reset  (s_axis_reset),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tready (s_axis_tready),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tready (m_axis_tready),
      .grant_o       (grant_o),
      .busy_o        (busy_o),
      .pkt_count_o   (pkt_count_o)
   );

   // 100 MHz clock
   initial s_axis_clk = 1'b0;
   always #5 s_axis_clk = ~s_axis_clk;

   // Hard stop in case the stimulus ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int p, input logic v, input logic l, input logic [31:0] d);
      s_axis_tvalid[p] = v;
      s_axis_tlast[p]  = l;
      pdata[p]         = d;
   endtask

   task automatic step();
      @(negedge s_axis_clk);
   endtask

   task automatic idle_all();
      for (int p = 0; p < NP; p++) drive(p, 1'b0, 1'b0, 32'h0);
   endtask

   // Directed scenarios
   initial begin
      int beat [NP];
      int exp_port, exp_beat, pkt, cyc, k, b;
      logic [3:0] pat;
      logic [3:0] exp_rdy;

      n_checks = 0;
      n_errors = 0;
      s_axis_reset  = 1'b1;
      m_axis_tready = 1'b1;
      idle_all();
      drive(0, 1'b1, 1'b0, 32'h55);

      // Reset with a request pending: nothing may pass
      step(); step(); step();
      #1;
      chk("rst_mvalid", 32'(m_axis_tvalid), 32'h0);
      s_axis_reset = 1'b0;
      drive(0, 1'b0, 1'b0, 32'h0);
      #1;
      chk("rst_grant", 32'(grant_o), 32'h0);
      chk("rst_busy",  32'(busy_o), 32'h0);
      chk("rst_count", 32'(pkt_count_o), 32'h0);
      chk("rst_sready", 32'(s_axis_tready), 32'h0);
      chk("rst_mvalid2", 32'(m_axis_tvalid), 32'h0);

      // Single requester: port 2, beats A0..A2
      step(); drive(2, 1'b1, 1'b0, 32'hA0); #1;
      chk("sr_idle_grant", 32'(grant_o), 32'h0);
      chk("sr_idle_mvalid", 32'(m_axis_tvalid), 32'h0);
      chk("sr_idle_sready", 32'(s_axis_tready), 32'h0);
      step(); #1;
      chk("sr_grant", 32'(grant_o), 32'h4);
      chk("sr_busy", 32'(busy_o), 32'h1);
      chk("sr_sready", 32'(s_axis_tready), 32'h4);
      chk("sr_d0", m_axis_tdata, 32'hA0);
      step(); drive(2, 1'b1, 1'b0, 32'hA1); #1;
      chk("sr_d1", m_axis_tdata, 32'hA1);
      chk("sr_d1_last", 32'(m_axis_tlast), 32'h0);
      step(); drive(2, 1'b1, 1'b1, 32'hA2); #1;
      chk("sr_d2", m_axis_tdata, 32'hA2);
      chk("sr_d2_last", 32'(m_axis_tlast), 32'h1);
      step(); drive(2, 1'b0, 1'b0, 32'h0); #1;
      chk("sr_end_busy", 32'(busy_o), 32'h0);
      chk("sr_end_grant", 32'(grant_o), 32'h0);
      chk("sr_end_count", 32'(pkt_count_o), 32'h1);
      chk("sr_end_mdata", m_axis_tdata, 32'h0);

      // Fairness: all ports send 2-beat packets back to back
      s_axis_reset = 1'b1;
      step();
      s_axis_reset = 1'b0;
      for (int p = 0; p < NP; p++) beat[p] = 0;
      exp_port = 0; exp_beat = 0; pkt = 0; cyc = 0;
      while (pkt < 8 && cyc < 100) begin
         step();
         for (int p = 0; p < NP; p++)
            drive(p, 1'b1, beat[p] == 1, 32'hB000 + 32'(p * 16 + beat[p]));
         #1;
         if (busy_o) chk("fair_grant", 32'(grant_o), 32'(1 << exp_port));
         if (m_axis_tvalid && m_axis_tready) begin
            chk("fair_data", m_axis_tdata, 32'hB000 + 32'(exp_port * 16 + exp_beat));
            if (exp_beat == 1) begin
               exp_beat = 0;
               exp_port = (exp_port + 1) % NP;
               pkt++;
            end else begin
               exp_beat = 1;
            end
         end
         for (int p = 0; p < NP; p++)
            if (s_axis_tready[p] && s_axis_tvalid[p]) beat[p] = (beat[p] == 1) ? 0 : 1;
         cyc++;
      end
      chk("fair_pkts_seen", 32'(pkt), 32'd8);
      step(); idle_all(); #1;
      chk("fair_count", 32'(pkt_count_o), 32'd8);
      chk("fair_busy", 32'(busy_o), 32'h0);

      // Backpressure: 4-beat packet on port 1, downstream ready 1,0,0,1,...
      pat = 4'b1001;
      k = 0; b = 0; cyc = 0;
      while (k < 4 && cyc < 60) begin
         step();
         drive(1, 1'b1, b == 3, 32'hC0 + 32'(b));
         m_axis_tready = pat[cyc % 4];
         #1;
         exp_rdy = (busy_o && m_axis_tready) ? 4'b0010 : 4'b0000;
         chk("bp_sready", 32'(s_axis_tready), 32'(exp_rdy));
         if (m_axis_tvalid && m_axis_tready) begin
            chk("bp_data", m_axis_tdata, 32'hC0 + 32'(k));
            chk("bp_last", 32'(m_axis_tlast), 32'(k == 3));
            k++;
            b++;
         end
         cyc++;
      end
      chk("bp_beats", 32'(k), 32'd4);
      step(); idle_all(); m_axis_tready = 1'b1; #1;
      chk("bp_count", 32'(pkt_count_o), 32'd9);

      // Lock: port 3 waits for port 0's tlast, then one IDLE cycle
      step(); drive(0, 1'b1, 1'b0, 32'hD0); #1;
      chk("lk_idle", 32'(grant_o), 32'h0);
      step(); drive(3, 1'b1, 1'b1, 32'hE0); #1;
      chk("lk_g0a", 32'(grant_o), 32'h1);
      chk("lk_d0", m_axis_tdata, 32'hD0);
      step(); drive(0, 1'b1, 1'b0, 32'hD1); #1;
      chk("lk_g0b", 32'(grant_o), 32'h1);
      chk("lk_d1", m_axis_tdata, 32'hD1);
      chk("lk_no3", 32'(s_axis_tready[3]), 32'h0);
      step(); drive(0, 1'b1, 1'b1, 32'hD2); #1;
      chk("lk_g0c", 32'(grant_o), 32'h1);
      chk("lk_d2", m_axis_tdata, 32'hD2);
      step(); drive(0, 1'b0, 1'b0, 32'h0); #1;
      chk("lk_gap_busy", 32'(busy_o), 32'h0);
      chk("lk_gap_grant", 32'(grant_o), 32'h0);
      chk("lk_gap_sready", 32'(s_axis_tready), 32'h0);
      step(); #1;
      chk("lk_g3", 32'(grant_o), 32'h8);
      chk("lk_e0", m_axis_tdata, 32'hE0);
      chk("lk_e0_last", 32'(m_axis_tlast), 32'h1);
      step(); drive(3, 1'b0, 1'b0, 32'h0); #1;
      chk("lk_single_busy", 32'(busy_o), 32'h0);
      chk("lk_count", 32'(pkt_count_o), 32'd11);

      // Mid-packet reset; priority must restart at port 0
      step(); drive(0, 1'b1, 1'b1, 32'hF0); #1;
      step(); #1;
      chk("mr_g0", 32'(grant_o), 32'h1);
      step(); drive(0, 1'b0, 1'b0, 32'h0); drive(1, 1'b1, 1'b0, 32'h90); #1;
      chk("mr_count12", 32'(pkt_count_o), 32'd12);
      step(); #1;
      chk("mr_g1", 32'(grant_o), 32'h2);
      chk("mr_b0", m_axis_tdata, 32'h90);
      step(); drive(1, 1'b1, 1'b0, 32'h91); s_axis_reset = 1'b1; #1;
      step(); s_axis_reset = 1'b0;
      drive(0, 1'b1, 1'b1, 32'h70); drive(1, 1'b1, 1'b0, 32'h92); #1;
      chk("mr_grant", 32'(grant_o), 32'h0);
      chk("mr_busy", 32'(busy_o), 32'h0);
      chk("mr_count", 32'(pkt_count_o), 32'h0);
      chk("mr_mvalid", 32'(m_axis_tvalid), 32'h0);
      step(); #1;
      chk("mr_prio0", 32'(grant_o), 32'h1);
      chk("mr_h0", m_axis_tdata, 32'h70);
      step(); idle_all(); #1;
      chk("mr_count1", 32'(pkt_count_o), 32'd1);
      step(); drive(1, 1'b1, 1'b1, 32'h93); #1;
      step(); #1;
      chk("mr_g1_alone", 32'(grant_o), 32'h2);
      step(); idle_all(); #1;
      chk("mr_count2", 32'(pkt_count_o), 32'd2);

      // Counter wrap: preset to 0xFFFF across a quiet edge, then finish one packet
      step();
      force dut.pkt_count_q = 16'hFFFF;
      step();
      release dut.pkt_count_q;
      #1;
      chk("wr_pre", 32'(pkt_count_o), 32'hFFFF);
      step(); drive(2, 1'b1, 1'b1, 32'h5A); #1;
      step(); #1;
      chk("wr_grant", 32'(grant_o), 32'h4);
      step(); idle_all(); #1;
      chk("wr_count", 32'(pkt_count_o), 32'h0);
      chk("wr_busy", 32'(busy_o), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
